// File: rtl/sound_player.sv
// sound_player: plays short note sequences from a fixed ROM as a square wave.
// One request latches a sound id; each note lasts NOTE_TICKS cycles and
// toggles the speaker every half-period cycles. done pulses when a sound ends
// on its own; a new request while playing restarts from the first note.
module sound_player #(
  parameter int unsigned NOTE_TICKS     = 2_500_000,
  parameter int unsigned TONE_DIV_SHIFT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       playsound,
  input  logic [1:0] soundselector,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic       done
);

  localparam int unsigned HP_W = 17;
  localparam int unsigned NT_W = (NOTE_TICKS > 1) ? $clog2(NOTE_TICKS) : 1;
  localparam logic [NT_W-1:0] NOTE_LAST = NT_W'(NOTE_TICKS - 1);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t            state, state_d;
  logic [1:0]        sel, sel_d;
  logic [1:0]        idx, idx_d;
  logic [NT_W-1:0]   timer, timer_d;
  logic [HP_W-1:0]   tcnt, tcnt_d;
  logic              tone, tone_d;
  logic              busy_d, done_d, speaker_d;

  logic [2:0]        note_code, next_code;
  logic [HP_W-1:0]   hp;
  logic              last_note;

  // Note ROM: 4 slots per sound, code 0 marks the end of a sound.
  function automatic logic [2:0] note_rom(input logic [1:0] s, input logic [1:0] i);
    logic [2:0] code;
    code = 3'd0;
    case ({s, i})
      4'b00_00: code = 3'd4;
      4'b01_00: code = 3'd1;
      4'b01_01: code = 3'd2;
      4'b01_10: code = 3'd3;
      4'b01_11: code = 3'd4;
      4'b10_00: code = 3'd5;
      4'b10_01: code = 3'd6;
      4'b11_00: code = 3'd1;
      4'b11_01: code = 3'd3;
      4'b11_10: code = 3'd4;
      4'b11_11: code = 3'd3;
      default:  code = 3'd0;
    endcase
    return code;
  endfunction

  // Half-period lookup, scaled down by TONE_DIV_SHIFT and clamped to >= 1.
  function automatic logic [HP_W-1:0] half_period(input logic [2:0] code);
    logic [HP_W-1:0] raw;
    logic [HP_W-1:0] shifted;
    raw = HP_W'(1);
    case (code)
      3'd1:    raw = HP_W'(23889);
      3'd2:    raw = HP_W'(18961);
      3'd3:    raw = HP_W'(15944);
      3'd4:    raw = HP_W'(11945);
      3'd5:    raw = HP_W'(56818);
      3'd6:    raw = HP_W'(75844);
      default: raw = HP_W'(1);
    endcase
    shifted = raw >> TONE_DIV_SHIFT;
    return (shifted == '0) ? HP_W'(1) : shifted;
  endfunction

  // Current note pitch and whether the next advance ends the sound.
  always_comb begin
    note_code = note_rom(sel, idx);
    next_code = note_rom(sel, 2'(idx + 2'd1));
    hp        = half_period(note_code);
    last_note = (idx == 2'd3) || (next_code == 3'd0) || (next_code == 3'd7);
  end

  // Next-state and next-output logic; restart wins over end of sound.
  always_comb begin
    state_d = state;
    sel_d   = sel;
    idx_d   = idx;
    timer_d = timer;
    tcnt_d  = tcnt;
    tone_d  = tone;
    busy_d  = busy;
    done_d  = 1'b0;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        if (playsound) begin
          state_d = PLAY;
          sel_d   = soundselector;
          idx_d   = 2'd0;
          timer_d = '0;
          tcnt_d  = '0;
          tone_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      PLAY: begin
        if (playsound) begin
          sel_d   = soundselector;
          idx_d   = 2'd0;
          timer_d = '0;
          tcnt_d  = '0;
          tone_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (timer == NOTE_LAST) begin
          timer_d = '0;
          tcnt_d  = '0;
          tone_d  = 1'b0;
          if (last_note) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d   = 2'(idx + 2'd1);
          end
        end else begin
          timer_d = NT_W'(timer + NT_W'(1));
          if (tcnt == HP_W'(hp - HP_W'(1))) begin
            tcnt_d = '0;
            tone_d = ~tone;
          end else begin
            tcnt_d = HP_W'(tcnt + HP_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    speaker_d = tone_d & busy_d & ~mute;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      sel     <= 2'd0;
      idx     <= 2'd0;
      timer   <= '0;
      tcnt    <= '0;
      tone    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      speaker <= 1'b0;
    end else begin
      state   <= state_d;
      sel     <= sel_d;
      idx     <= idx_d;
      timer   <= timer_d;
      tcnt    <= tcnt_d;
      tone    <= tone_d;
      busy    <= busy_d;
      done    <= done_d;
      speaker <= speaker_d;
    end
  end

endmodule

// File: tb/tb_sound_player.sv
// Directed bench for sound_player with NOTE_TICKS=200, TONE_DIV_SHIFT=8.
// Effective half-periods: C5=93, E5=74, G5=62, C6=46, A3=221, E3=296.
// cyc = j means the outputs seen after the (j)th edge following the request edge.
module tb_sound_player;

  logic       clk;
  logic       reset;
  logic       playsound;
  logic [1:0] soundselector;
  logic       mute;
  logic       speaker;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  int cyc;
  int n_busy;
  int n_done;
  int n_high;
  int done_cyc;
  int rises[$];
  logic prev_spk;

  sound_player #(
    .NOTE_TICKS    (200),
    .TONE_DIV_SHIFT(8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .playsound    (playsound),
    .soundselector(soundselector),
    .mute         (mute),
    .speaker      (speaker),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task clear_stats();
    n_busy   = 0;
    n_done   = 0;
    n_high   = 0;
    done_cyc = -1;
    rises.delete();
    prev_spk = speaker;
  endtask

  // Advance one cycle and sample outputs on the falling edge.
  task tick();
    @(negedge clk);
    cyc++;
    if (speaker === 1'b1 && prev_spk !== 1'b1) rises.push_back(cyc);
    prev_spk = speaker;
    if (busy === 1'b1) n_busy++;
    if (speaker === 1'b1) n_high++;
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task run_to(input int c);
    while (cyc < c) tick();
  endtask

  // One-cycle request issued from the current falling edge.
  task start(input logic [1:0] s);
    soundselector = s;
    playsound     = 1'b1;
    cyc           = -1;
    clear_stats();
    tick();
    playsound     = 1'b0;
  endtask

  function automatic int rise_at(input int i);
    return (i < rises.size()) ? rises[i] : -1;
  endfunction

  int exp_rises1[6] = '{93, 274, 462, 586, 646, 738};

  initial begin
    reset         = 1'b1;
    playsound     = 1'b1;
    soundselector = 2'd0;
    mute          = 1'b0;
    cyc           = 0;
    clear_stats();
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_speaker", 32'(speaker), 0);
    check("rst_done", 32'(done), 0);
    reset     = 1'b0;
    playsound = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);

    // UI_PRESS; selector change mid-play must be ignored
    start(2'd0);
    check("ui_busy0", 32'(busy), 1);
    check("ui_spk0", 32'(speaker), 0);
    soundselector = 2'd3;
    run_to(205);
    check("ui_nbusy", n_busy, 200);
    check("ui_ndone", n_done, 1);
    check("ui_donecyc", done_cyc, 200);
    check("ui_nrises", rises.size(), 2);
    check("ui_rise0", rise_at(0), 46);
    check("ui_rise1", rise_at(1), 138);
    check("ui_spk_end", 32'(speaker), 0);
    check("ui_busy_end", 32'(busy), 0);

    // NEXTLEVEL: four notes, one rise-list per window
    start(2'd1);
    run_to(805);
    check("nl_nbusy", n_busy, 800);
    check("nl_ndone", n_done, 1);
    check("nl_donecyc", done_cyc, 800);
    check("nl_nrises", rises.size(), 6);
    for (int i = 0; i < 6; i++) check($sformatf("nl_rise%0d", i), rise_at(i), exp_rises1[i]);

    // CRASH restarted by CELEBRATION at cycle 150
    start(2'd2);
    run_to(149);
    check("rs_busy_pre", 32'(busy), 1);
    start(2'd3);
    check("rs_busy0", 32'(busy), 1);
    check("rs_spk0", 32'(speaker), 0);
    run_to(805);
    check("rs_nbusy", n_busy, 800);
    check("rs_ndone", n_done, 1);
    check("rs_donecyc", done_cyc, 800);
    check("rs_nrises", rises.size(), 7);
    check("rs_rise0", rise_at(0), 93);
    check("rs_rise6", rise_at(6), 786);

    // CRASH muted throughout
    mute = 1'b1;
    start(2'd2);
    run_to(405);
    mute = 1'b0;
    check("mu_nhigh", n_high, 0);
    check("mu_nbusy", n_busy, 400);
    check("mu_ndone", n_done, 1);
    check("mu_donecyc", done_cyc, 400);

    // Mute pulsed while a tone is high
    start(2'd0);
    run_to(50);
    check("mp_spk_on", 32'(speaker), 1);
    mute = 1'b1;
    tick();
    check("mp_spk_muted", 32'(speaker), 0);
    check("mp_busy", 32'(busy), 1);
    run_to(60);
    mute = 1'b0;
    tick();
    check("mp_spk_back", 32'(speaker), 1);
    run_to(205);
    check("mp_ndone", n_done, 1);
    check("mp_donecyc", done_cyc, 200);

    // Reset at cycle 300 of CELEBRATION, then immediate replay
    start(2'd3);
    run_to(299);
    check("rr_spk_pre", 32'(speaker), 1);
    reset = 1'b1;
    tick();
    check("rr_busy", 32'(busy), 0);
    check("rr_spk", 32'(speaker), 0);
    check("rr_done", 32'(done), 0);
    reset = 1'b0;
    start(2'd0);
    check("rr_busy_new", 32'(busy), 1);
    run_to(205);
    check("rr_nbusy", n_busy, 200);
    check("rr_ndone", n_done, 1);
    check("rr_rise0", rise_at(0), 46);

    // playsound held high: restart every cycle
    soundselector = 2'd0;
    playsound     = 1'b1;
    cyc           = -1;
    clear_stats();
    run_to(299);
    check("hd_nbusy", n_busy, 300);
    check("hd_nhigh", n_high, 0);
    check("hd_ndone", n_done, 0);
    playsound = 1'b0;
    run_to(505);
    check("hd_ndone_after", n_done, 1);
    check("hd_donecyc", done_cyc, 499);
    check("hd_rise0", rise_at(0), 345);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sound_player.md
SOUND_PLAYER -- requirements
Module: sound_player

Interface
REQ-001 SHALL have parameter NOTE_TICKS, default 2_500_000, giving note duration in clk cycles (100 ms at 25 MHz).
REQ-002 SHALL have parameter TONE_DIV_SHIFT, default 0, giving the right-shift applied to every half-period table entry (the bench uses it to shrink tones).
REQ-003 SHALL have port clk  input  1  system clock, single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port playsound  input  1  request strobe from the game state controller, sampled every clk edge.
REQ-006 SHALL have port soundselector  input  2  sound id: 0 UI_PRESS, 1 NEXTLEVEL, 2 CRASH, 3 CELEBRATION.
REQ-007 SHALL have port mute  input  1  when high, forces the speaker low without stopping sequencing.
REQ-008 SHALL have port speaker  output  1  square-wave drive to the piezo/amp pin.
REQ-009 SHALL have port busy  output  1  high while a sound is sequencing.
REQ-010 SHALL have port done  output  1  one-cycle pulse when a sound completes naturally.

Function
REQ-011 SHALL implement the states IDLE and PLAY.
REQ-012 SHALL use a fixed note ROM of 4 slots per sound, each slot a 3-bit pitch code, where code 0 means end of sound.
REQ-013 SHALL use these sequences: UI_PRESS = 4; NEXTLEVEL = 1,2,3,4; CRASH = 5,6; CELEBRATION = 1,3,4,3.
REQ-014 SHALL use these half-periods, in cycles before the shift: 1 = 23889 (C5), 2 = 18961 (E5), 3 = 15944 (G5), 4 = 11945 (C6), 5 = 56818 (A3), 6 = 75844 (E3), 7 = treated as end code.
REQ-015 SHALL hold the effective half-period HP = table >> TONE_DIV_SHIFT in a 17-bit counter; if HP evaluates to 0 it SHALL be treated as 1.
REQ-016 SHALL, when in IDLE with playsound=1 at edge k, latch soundselector, set note index 0, clear the note timer and tone counter, and drive speaker=0 and busy=1 from k+1.
REQ-017 SHALL count the tone counter from 0 to HP-1; on the edge where it equals HP-1 it SHALL wrap to 0 and toggle the internal tone bit, so the first rising edge on speaker occurs at k+HP.
REQ-018 SHALL count the note timer from 0 to NOTE_TICKS-1; at its terminal count it SHALL advance the note index, clear both counters and clear the tone bit.
REQ-019 SHALL make the advance after slot 3, or into a slot holding code 0 or 7, end the sound: state returns to IDLE, busy=0 and done=1 for exactly that one cycle.
REQ-020 SHALL therefore keep busy high for exactly N*NOTE_TICKS cycles, where N is the number of notes in the sound (1, 4, 2 or 4).
REQ-021 SHALL restart when playsound=1 arrives while in PLAY: the new selector is latched, the note index and counters are cleared, the tone bit is cleared, busy stays 1 and no done pulse is produced.
REQ-022 SHALL give the restart priority when a restart coincides with the end of a sound: no done pulse, and playback starts again from note 0.
REQ-023 SHALL drive speaker = tone bit AND busy AND NOT mute, registered, so speaker is 0 whenever the block is IDLE.
REQ-024 SHALL ignore soundselector changes during PLAY unless playsound=1.
REQ-025 SHALL have no combinational path from inputs to outputs.

Reset
REQ-026 SHALL, on reset=1 at any edge, enter IDLE and set speaker=0, busy=0, done=0, all counters and the note index to 0, and the latched selector to 0.
REQ-027 SHALL give reset priority over playsound; a sound interrupted by reset SHALL not produce a done pulse.
REQ-028 SHALL, on the first edge after reset deasserts, accept a playsound request as in REQ-016.

Verification (NOTE_TICKS=200, TONE_DIV_SHIFT=8)
REQ-029 SHALL cover: playsound=1 with selector 0 for one cycle -> busy high for 200 cycles; speaker toggles every 46 cycles, first rise 46 cycles after the request edge; done pulses once; speaker is 0 afterwards.
REQ-030 SHALL cover: selector 1 -> busy high for 800 cycles, with speaker half-periods of 93, 74, 62 and 46 cycles in successive 200-cycle windows, then one done pulse.
REQ-031 SHALL cover: selector 2 started, then playsound with selector 3 at cycle 150 -> busy stays high, speaker immediately drops to 0 and restarts with half-period 93, busy lasts 800 more cycles, no done pulse at cycle 400.
REQ-032 SHALL cover: mute=1 throughout a CRASH sound -> speaker constant 0, busy high for 400 cycles, done pulses once.
REQ-033 SHALL cover: reset asserted at cycle 300 of CELEBRATION -> the next cycle has busy=0, speaker=0 and done=0; a playsound issued after reset plays normally.
REQ-034 SHALL cover: playsound held high continuously -> the sound restarts every cycle, busy stays 1, speaker stays 0 and done never pulses.
